// File: rtl/calc1_pkg.sv
// Shared types and encodings for the calc1 request driver and its wait timer.
package calc1_pkg;

    localparam int CMD_W_DEF  = 4;
    localparam int DATA_W_DEF = 32;

    localparam logic [3:0] CMD_NOP = 4'd0;
    localparam logic [3:0] CMD_ADD = 4'd1;
    localparam logic [3:0] CMD_SUB = 4'd2;
    localparam logic [3:0] CMD_SHL = 4'd5;
    localparam logic [3:0] CMD_SHR = 4'd6;

    localparam logic [1:0] RESP_NONE = 2'b00;
    localparam logic [1:0] RESP_OK   = 2'b01;
    localparam logic [1:0] RESP_ERR  = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SEND1 = 3'd1,
        ST_SEND2 = 3'd2,
        ST_WAIT  = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

endpackage

// File: rtl/calc1_wait_timer.sv
// Saturating cycle counter for the WAIT state; expired once the count
// reaches TIMEOUT_CYCLES-1 and holds there until cleared.
module calc1_wait_timer #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && (count != LAST)) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/calc1_req_driver.sv
// Drives one calc1 transaction at a time over the two-cycle request protocol
// and returns the captured response (or a timeout) to the downstream stage.
module calc1_req_driver
    import calc1_pkg::*;
#(
    parameter int DATA_W         = DATA_W_DEF,
    parameter int CMD_W          = CMD_W_DEF,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              c_clk,
    input  logic              reset,
    input  logic              txn_valid,
    output logic              txn_ready,
    input  logic [CMD_W-1:0]  txn_cmd,
    input  logic [DATA_W-1:0] txn_op1,
    input  logic [DATA_W-1:0] txn_op2,
    output logic [CMD_W-1:0]  req_cmd_out,
    output logic [DATA_W-1:0] req_data_out,
    input  logic [1:0]        calc_resp_in,
    input  logic [DATA_W-1:0] calc_data_in,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [1:0]        rsp_code,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_timeout,
    output logic              stray_resp,
    output logic              busy,
    output logic [2:0]        state_dbg
);

    // Handshakes: a transfer happens on an edge where valid && ready are both
    // high; valid-side payload is held stable until that edge.
    state_t            state;
    logic [DATA_W-1:0] op2_q;
    logic              timer_expired;

    calc1_wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk    (c_clk),
        .reset  (reset),
        .clear  (state == ST_SEND2),
        .enable (state == ST_WAIT),
        .expired(timer_expired)
    );

    always_ff @(posedge c_clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            op2_q        <= '0;
            txn_ready    <= 1'b1;
            req_cmd_out  <= '0;
            req_data_out <= '0;
            rsp_valid    <= 1'b0;
            rsp_code     <= RESP_NONE;
            rsp_data     <= '0;
            rsp_timeout  <= 1'b0;
            stray_resp   <= 1'b0;
        end else begin
            if ((calc_resp_in != RESP_NONE) && (state != ST_WAIT)) begin
                stray_resp <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (txn_valid) begin
                        txn_ready <= 1'b0;
                        op2_q     <= txn_op2;
                        if (txn_cmd == '0) begin
                            // A NOP is rejected locally; calc1 never sees it.
                            rsp_valid   <= 1'b1;
                            rsp_code    <= RESP_ERR;
                            rsp_data    <= '0;
                            rsp_timeout <= 1'b0;
                            state       <= ST_RESP;
                        end else begin
                            req_cmd_out  <= txn_cmd;
                            req_data_out <= txn_op1;
                            state        <= ST_SEND1;
                        end
                    end
                end
                ST_SEND1: begin
                    req_cmd_out  <= '0;
                    req_data_out <= op2_q;
                    state        <= ST_SEND2;
                end
                ST_SEND2: begin
                    req_data_out <= '0;
                    state        <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A response arriving on the expiry cycle takes priority.
                    if (calc_resp_in != RESP_NONE) begin
                        rsp_valid   <= 1'b1;
                        rsp_code    <= calc_resp_in;
                        rsp_data    <= calc_data_in;
                        rsp_timeout <= 1'b0;
                        state       <= ST_RESP;
                    end else if (timer_expired) begin
                        rsp_valid   <= 1'b1;
                        rsp_code    <= RESP_NONE;
                        rsp_data    <= '0;
                        rsp_timeout <= 1'b1;
                        state       <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid   <= 1'b0;
                        rsp_code    <= RESP_NONE;
                        rsp_data    <= '0;
                        rsp_timeout <= 1'b0;
                        txn_ready   <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy      = (state != ST_IDLE);
    assign state_dbg = state;

endmodule

// File: tb/tb_calc1_req_driver.sv
// Directed and randomized bench for calc1_req_driver with a behavioural calc1 model.
module tb_calc1_req_driver;

    localparam int DW = 32;
    localparam int CW = 4;
    localparam int TO = 16;

    logic          c_clk;
    logic          reset;
    logic          txn_valid;
    logic          txn_ready;
    logic [CW-1:0] txn_cmd;
    logic [DW-1:0] txn_op1;
    logic [DW-1:0] txn_op2;
    logic [CW-1:0] req_cmd_out;
    logic [DW-1:0] req_data_out;
    logic [1:0]    calc_resp_in;
    logic [DW-1:0] calc_data_in;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [1:0]    rsp_code;
    logic [DW-1:0] rsp_data;
    logic          rsp_timeout;
    logic          stray_resp;
    logic          busy;
    logic [2:0]    state_dbg;

    int total;
    int passed;
    bit stray_exp;

    calc1_req_driver #(
        .DATA_W(DW),
        .CMD_W(CW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .c_clk       (c_clk),
        .reset       (reset),
        .txn_valid   (txn_valid),
        .txn_ready   (txn_ready),
        .txn_cmd     (txn_cmd),
        .txn_op1     (txn_op1),
        .txn_op2     (txn_op2),
        .req_cmd_out (req_cmd_out),
        .req_data_out(req_data_out),
        .calc_resp_in(calc_resp_in),
        .calc_data_in(calc_data_in),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_code    (rsp_code),
        .rsp_data    (rsp_data),
        .rsp_timeout (rsp_timeout),
        .stray_resp  (stray_resp),
        .busy        (busy),
        .state_dbg   (state_dbg)
    );

    initial c_clk = 1'b0;
    always #5 c_clk = ~c_clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge c_clk);
        #1;
    endtask

    // calc1 behaviour: add/sub flag carry/borrow, shifts use op2[4:0], others invalid.
    function automatic void calc_model(input logic [3:0] cmd, input logic [31:0] a,
                                       input logic [31:0] b, output logic [1:0] code,
                                       output logic [31:0] data);
        logic [32:0] wide;
        code = 2'b01;
        data = '0;
        case (cmd)
            4'd1: begin
                wide = {1'b0, a} + {1'b0, b};
                data = wide[31:0];
                if (wide[32]) code = 2'b10;
            end
            4'd2: begin
                data = a - b;
                if (b > a) code = 2'b10;
            end
            4'd5: data = a << b[4:0];
            4'd6: data = a >> b[4:0];
            default: code = 2'b10;
        endcase
    endfunction

    // Entered #1 after the edge on which the response was captured.
    task automatic handshake(input logic [1:0] code, input logic [31:0] data,
                             input logic to, input int hold);
        check("rsp_valid", rsp_valid, 1);
        check("rsp_code", rsp_code, code);
        check("rsp_data", rsp_data, data);
        check("rsp_timeout", rsp_timeout, to);
        check("txn_ready_in_resp", txn_ready, 0);
        check("stray_resp", stray_resp, stray_exp);
        for (int h = 0; h < hold; h++) begin
            step();
            check("hold_valid", rsp_valid, 1);
            check("hold_code", rsp_code, code);
            check("hold_data", rsp_data, data);
            check("hold_timeout", rsp_timeout, to);
            check("hold_txn_ready", txn_ready, 0);
            check("hold_req_cmd", req_cmd_out, 0);
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("post_rsp_valid", rsp_valid, 0);
        check("post_txn_ready", txn_ready, 1);
        check("post_busy", busy, 0);
    endtask

    task automatic run_txn(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                           input int delay, input bit respond, input int hold, input bit inject,
                           output logic [1:0] got_code, output logic [31:0] got_data);
        logic [1:0]  code;
        logic [31:0] data;
        int n;
        n = 0;
        while (!txn_ready && n < 50) begin
            step();
            n++;
        end
        check("txn_ready_wait", txn_ready, 1);
        txn_valid = 1'b1;
        txn_cmd   = cmd;
        txn_op1   = a;
        txn_op2   = b;
        step();
        txn_valid = 1'b0;
        txn_op1   = $urandom;
        txn_op2   = $urandom;
        got_code  = rsp_code;
        got_data  = rsp_data;
        if (cmd == 4'd0) begin
            check("nop_req_cmd", req_cmd_out, 0);
            check("nop_req_data", req_data_out, 0);
            got_code = rsp_code;
            got_data = rsp_data;
            handshake(2'b10, 32'd0, 1'b0, hold);
            return;
        end
        if (inject) begin
            calc_resp_in = 2'b01;
            stray_exp    = 1'b1;
        end
        check("send1_cmd", req_cmd_out, cmd);
        check("send1_data", req_data_out, a);
        step();
        calc_resp_in = 2'b00;
        check("send2_cmd", req_cmd_out, 0);
        check("send2_data", req_data_out, b);
        calc_model(cmd, a, b, code, data);
        step();
        check("wait_req_data", req_data_out, 0);
        if (respond) begin
            repeat (delay) step();
            calc_resp_in = code;
            calc_data_in = data;
            step();
            calc_resp_in = 2'b00;
            calc_data_in = $urandom;
            got_code = rsp_code;
            got_data = rsp_data;
            handshake(code, data, 1'b0, hold);
        end else begin
            n = 0;
            while (!rsp_valid && n < 40) begin
                step();
                n++;
            end
            check("timeout_cycles", n, TO);
            got_code = rsp_code;
            got_data = rsp_data;
            handshake(2'b00, 32'd0, 1'b1, hold);
        end
    endtask

    initial begin
        logic [1:0]  gc;
        logic [31:0] gd;
        logic [31:0] x;
        logic [3:0]  cmd_pool [7];
        bit          seen;
        total        = 0;
        passed       = 0;
        stray_exp    = 1'b0;
        reset        = 1'b1;
        txn_valid    = 1'b0;
        txn_cmd      = '0;
        txn_op1      = '0;
        txn_op2      = '0;
        calc_resp_in = 2'b00;
        calc_data_in = '0;
        rsp_ready    = 1'b0;
        cmd_pool     = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd6, 4'd3, 4'd9};
        repeat (3) step();
        reset = 1'b0;
        step();

        check("rst_txn_ready", txn_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_req_cmd", req_cmd_out, 0);
        check("rst_req_data", req_data_out, 0);
        check("rst_rsp_code", rsp_code, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_timeout", rsp_timeout, 0);
        check("rst_stray", stray_resp, 0);

        run_txn(4'd1, 32'd1, 32'd1, 0, 1'b1, 0, 1'b0, gc, gd);
        check("add_1_1_code", gc, 2'b01);
        check("add_1_1_data", gd, 32'd2);

        for (int k = 0; k <= 30; k++) begin
            x = 32'd1 << k;
            run_txn(4'd1, x, 32'd0, $urandom_range(0, 4), 1'b1, $urandom_range(0, 2), 1'b0, gc, gd);
            check("walk_data", gd, x);
            check("walk_code", gc, 2'b01);
        end

        run_txn(4'd1, 32'hFFFF_FFFF, 32'd1, 2, 1'b1, 0, 1'b0, gc, gd);
        check("ovf_code", gc, 2'b10);
        run_txn(4'd5, 32'd1, 32'd31, 1, 1'b1, 0, 1'b0, gc, gd);
        check("shl31_code", gc, 2'b01);
        check("shl31_data", gd, 32'h8000_0000);

        run_txn(4'd0, 32'h1234, 32'h5678, 0, 1'b1, 2, 1'b0, gc, gd);
        check("nop_code", gc, 2'b10);
        check("nop_data", gd, 32'd0);

        run_txn(4'd2, 32'd5, 32'd3, 0, 1'b0, 1, 1'b0, gc, gd);
        check("timeout_code", gc, 2'b00);
        check("timeout_data", gd, 32'd0);

        // Response on the same cycle the timer expires.
        run_txn(4'd2, 32'd9, 32'd4, TO - 1, 1'b1, 0, 1'b0, gc, gd);
        check("late_resp_data", gd, 32'd5);

        run_txn(4'd6, 32'hF000_0000, 32'd4, 3, 1'b1, 5, 1'b0, gc, gd);
        check("shr_data", gd, 32'h0F00_0000);

        for (int i = 0; i < 20; i++) begin
            run_txn(cmd_pool[$urandom_range(0, 6)], $urandom, $urandom_range(0, 40),
                    $urandom_range(0, TO - 1), 1'b1, $urandom_range(0, 3), 1'b0, gc, gd);
        end

        // Reset while waiting on calc1 drops the transaction silently.
        txn_valid = 1'b1;
        txn_cmd   = 4'd1;
        txn_op1   = 32'd7;
        txn_op2   = 32'd8;
        step();
        txn_valid = 1'b0;
        repeat (5) step();
        check("pre_reset_state", state_dbg, 3'd3);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid_reset_busy", busy, 0);
        check("mid_reset_txn_ready", txn_ready, 1);
        check("mid_reset_rsp_valid", rsp_valid, 0);
        seen = 1'b0;
        for (int i = 0; i < 25; i++) begin
            step();
            if (rsp_valid) seen = 1'b1;
        end
        check("mid_reset_no_rsp", seen, 0);

        run_txn(4'd1, 32'd40, 32'd2, 1, 1'b1, 0, 1'b1, gc, gd);
        check("stray_txn_data", gd, 32'd42);
        repeat (3) step();
        check("stray_sticky", stray_resp, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        stray_exp = 1'b0;
        check("stray_cleared", stray_resp, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/calc1_req_driver.md
Name: calc1_req_driver

Overview:
Upstream stage for the calc1 adder/shifter port. Accepts one arithmetic transaction (cmd, op1, op2) over a valid/ready handshake and drives it onto the calc1 request port using the two-cycle protocol: cmd with op1, then op2. It then waits for the calc1 response, with a timeout, and returns code and result over a valid/ready response handshake. One outstanding transaction at a time.

Parameters:
DATA_W, 32, operand/result width
CMD_W, 4, command width
TIMEOUT_CYCLES, 64, max cycles in WAIT before a timeout is reported (legal range 2..1023)

Ports:
c_clk  in  1  clock
reset  in  1  synchronous, active-high reset
txn_valid  in  1  upstream transaction valid
txn_ready  out  1  driver can accept a transaction
txn_cmd  in  CMD_W  command (1 add, 2 sub, 5 shl, 6 shr, others forwarded)
txn_op1  in  DATA_W  operand 1
txn_op2  in  DATA_W  operand 2 / shift amount
req_cmd_out  out  CMD_W  to calc1 cmd_in
req_data_out  out  DATA_W  to calc1 data_in
calc_resp_in  in  2  from calc1 resp (00 none, 01 ok, 10 overflow/underflow/invalid)
calc_data_in  in  DATA_W  from calc1 data_out
rsp_valid  out  1  response valid
rsp_ready  in  1  downstream accepts response
rsp_code  out  2  captured calc1 resp code
rsp_data  out  DATA_W  captured calc1 result
rsp_timeout  out  1  response is a timeout
stray_resp  out  1  sticky: nonzero calc_resp_in seen outside WAIT
busy  out  1  state != IDLE

Behaviour:
- Reset: state IDLE. All outputs 0 except txn_ready=1. Wait counter 0, stray_resp 0.
- Reset mid-operation: next edge returns to IDLE and drops the in-flight transaction. No response is emitted. calc1 shares the same reset.
- IDLE: txn_ready=1, req_cmd_out=0, req_data_out=0. On txn_valid at an edge, capture cmd/op1/op2.
  - cmd==0 -> go to RESP with rsp_code=10, rsp_data=0, rsp_timeout=0; the calc port is never driven.
  - Otherwise -> go to SEND1.
- SEND1 (1 cycle): req_cmd_out=cmd, req_data_out=op1. Go to SEND2.
- SEND2 (1 cycle): req_cmd_out=0, req_data_out=op2. Go to WAIT and clear the counter.
- WAIT: req_cmd_out=0, req_data_out=0. Sample calc_resp_in each cycle.
  - Nonzero -> capture rsp_code and rsp_data=calc_data_in, go to RESP.
  - Else the counter increments. If counter==TIMEOUT_CYCLES-1 with no response -> go to RESP with rsp_timeout=1, rsp_code=00, rsp_data=0.
  - A response and timeout in the same cycle: the response wins, rsp_timeout=0.
- RESP: rsp_valid=1. rsp_code/rsp_data/rsp_timeout stay stable until rsp_valid&&rsp_ready, then go to IDLE. txn_ready=0 throughout.
- Latency: accept at edge T. Cmd is on the port during T..T+1, op2 during T+1..T+2. Earliest response sampled at T+3. rsp_valid asserts the cycle after capture.
- Throughput: a new txn is accepted only in IDLE. There is no IDLE bypass from RESP, so back-to-back transactions have a minimum spacing of 5 cycles.
- Data and commands are forwarded unmodified; no arithmetic or width conversion in the driver. Results wrap per calc1.
- stray_resp: set when calc_resp_in!=0 in any state other than WAIT; cleared only by reset. The stray value is otherwise ignored.
- Counter width is clog2(TIMEOUT_CYCLES). It saturates and never wraps.

Decomposition:
- calc1_pkg:
  - CMD_W/DATA_W defaults
  - command encodings CMD_NOP=0, CMD_ADD=1, CMD_SUB=2, CMD_SHL=5, CMD_SHR=6
  - response codes RESP_NONE=00, RESP_OK=01, RESP_ERR=10
  - state enum IDLE/SEND1/SEND2/WAIT/RESP
- One sub-module: calc1_wait_timer. Inputs clear and enable; outputs expired at TIMEOUT_CYCLES-1; saturating.

Test Plan:
- Add 1+1 with the calc1 model: SEND1 shows cmd=1/data=1, SEND2 shows data=1 -> rsp_code=01, rsp_data=2, rsp_timeout=0.
- Walking-bit add x+0 for x=1<<k, k=0..30 -> rsp_data==x, code 01 for every k; one txn per handshake.
- Overflow 0xFFFFFFFF+1 -> rsp_code=10. Shl 1 by 31 -> rsp_data=0x80000000, code 01.
- txn_cmd=0 -> RESP the next cycle with code 10; req_cmd_out stays 0 every cycle.
- Stub calc that never responds, TIMEOUT_CYCLES=16 -> rsp_timeout=1 on the 17th cycle after WAIT entry; code 00, data 0.
- Hold rsp_ready=0 for 5 cycles in RESP -> outputs stable, txn_ready=0. Assert reset during WAIT -> IDLE the next cycle, no rsp_valid. A stray resp during SEND1 -> stray_resp=1 until reset.
